mux_operand_loader: RTL and testbench



---
 rtl/mux_operand_loader.sv | 108 ++++++++++
 tb/tb_mux_operand_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_operand_loader.sv
// mux_operand_loader: collects a, b, c (and sel with c) one word at a time
// and presents them as a registered frame to the select/mux stage. A frame
// is held for at least MIN_HOLD cycles so the downstream mux can settle.
//
// Input handshake:  a word moves on a rising edge where in_valid && in_ready.
// Output handshake: a frame is released on a rising edge where out_valid &&
//                   out_ack && the minimum hold has elapsed; acks arriving
//                   before that point are dropped, not remembered.
// flush discards the partial or presented frame, and outranks both handshakes.
module mux_operand_loader #(
  parameter int WIDTH    = 4,
  parameter int MIN_HOLD = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [CNT_W-1:0] frame_count,
  output logic [1:0]       state_dbg
);

  localparam int HOLD_W = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_C  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold;
  logic              hold_done;
  logic              xfer;

  // Loader accepts words in any load state; never while in reset.
  assign in_ready  = ~rst & (state != PRESENT);
  assign xfer      = in_valid & in_ready;
  assign hold_done = (hold >= HOLD_W'(MIN_HOLD));
  assign state_dbg = state;

  // Frame assembly, hold timing, release and frame counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD_A;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      sel         <= 1'b0;
      out_valid   <= 1'b0;
      hold        <= '0;
      frame_count <= '0;
    end else if (flush) begin
      // Operands keep their values; only the frame progress is abandoned.
      state     <= LOAD_A;
      out_valid <= 1'b0;
      hold      <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (xfer) begin
            a     <= in_data;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (xfer) begin
            b     <= in_data;
            state <= LOAD_C;
          end
        end
        LOAD_C: begin
          if (xfer) begin
            c         <= in_data;
            sel       <= in_sel;
            hold      <= '0;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ack && hold_done) begin
            out_valid   <= 1'b0;
            frame_count <= frame_count + CNT_W'(1);
            state       <= LOAD_A;
          end else if (!hold_done) begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: begin
          state     <= LOAD_A;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_operand_loader.sv
// Bench for mux_operand_loader: a directed vector table covering the
// documented frame sequences, then a long randomized run compared every
// cycle against a frame-level reference model.
module tb_mux_operand_loader;

  localparam int WIDTH    = 4;
  localparam int MIN_HOLD = 2;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, c;
  logic             sel;
  logic             out_valid;
  logic             out_ack = 1'b0;
  logic [CNT_W-1:0] frame_count;
  logic [1:0]       state_dbg;

  int total = 0;
  int bad   = 0;

  mux_operand_loader #(.WIDTH(WIDTH), .MIN_HOLD(MIN_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .sel(sel),
    .out_valid(out_valid), .out_ack(out_ack),
    .frame_count(frame_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Frame-level view: how many words of the current frame have arrived,
  // whether a frame is on display, and for how many cycles it has been shown.
  int   m_words;
  bit   m_showing;
  int   m_shown;
  int   m_a, m_b, m_c, m_sel;
  int   m_cnt;

  function automatic void model_edge();
    if (rst) begin
      m_words = 0; m_showing = 0; m_shown = 0;
      m_a = 0; m_b = 0; m_c = 0; m_sel = 0; m_cnt = 0;
    end else if (flush) begin
      m_words = 0; m_showing = 0; m_shown = 0;
    end else if (m_showing) begin
      if (out_ack && m_shown >= MIN_HOLD) begin
        m_showing = 0;
        m_words   = 0;
        m_cnt     = (m_cnt + 1) % (1 << CNT_W);
      end else begin
        m_shown = m_shown + 1;
      end
    end else if (in_valid) begin
      if (m_words == 0) m_a = int'(in_data);
      else if (m_words == 1) m_b = int'(in_data);
      else begin
        m_c = int'(in_data);
        m_sel = int'(in_sel);
        m_showing = 1;
        m_shown = 0;
      end
      m_words = m_showing ? 0 : m_words + 1;
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_a", int'(a), m_a);
    chk("m_b", int'(b), m_b);
    chk("m_c", int'(c), m_c);
    chk("m_sel", int'(sel), m_sel);
    chk("m_out_valid", int'(out_valid), int'(m_showing));
    chk("m_in_ready", int'(in_ready), int'(!rst && !m_showing));
    chk("m_frame_count", int'(frame_count), m_cnt);
  endtask

  // One clock: DUT and model see the same inputs on the rising edge,
  // outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       rst, flush, in_valid, in_sel, out_ack;
    logic [3:0] in_data;
    logic       e_ov, e_ir;
    logic [3:0] e_a, e_b, e_c;
    logic       e_sel;
    int         e_cnt;
  } vec_t;

  vec_t vt[29];

  function automatic vec_t mk(input logic r, input logic f, input logic v,
                              input logic [3:0] d, input logic s, input logic k,
                              input logic ov, input logic ir,
                              input logic [3:0] ea, input logic [3:0] eb,
                              input logic [3:0] ec, input logic es, input int ecnt);
    vec_t t;
    t.rst = r; t.flush = f; t.in_valid = v; t.in_data = d; t.in_sel = s; t.out_ack = k;
    t.e_ov = ov; t.e_ir = ir; t.e_a = ea; t.e_b = eb; t.e_c = ec; t.e_sel = es;
    t.e_cnt = ecnt;
    return t;
  endfunction

  initial begin
    //           rst flush v  data  s  ack | ov ir  a    b    c   sel cnt
    vt[0]  = mk(1, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    // 3,5,9 sel=1 back-to-back with ack held: released in 3rd PRESENT cycle
    vt[1]  = mk(0, 0, 1, 4'h3, 0, 1,  0, 1, 4'h3, 4'h0, 4'h0, 0, 0);
    vt[2]  = mk(0, 0, 1, 4'h5, 0, 1,  0, 1, 4'h3, 4'h5, 4'h0, 0, 0);
    vt[3]  = mk(0, 0, 1, 4'h9, 1, 1,  1, 0, 4'h3, 4'h5, 4'h9, 1, 0);
    vt[4]  = mk(0, 0, 0, 4'h0, 0, 1,  1, 0, 4'h3, 4'h5, 4'h9, 1, 0);
    vt[5]  = mk(0, 0, 0, 4'h0, 0, 1,  1, 0, 4'h3, 4'h5, 4'h9, 1, 0);
    vt[6]  = mk(0, 0, 0, 4'h0, 0, 1,  0, 1, 4'h3, 4'h5, 4'h9, 1, 1);
    // early ack dropped, re-asserted in 4th PRESENT cycle
    vt[7]  = mk(0, 0, 1, 4'h1, 0, 0,  0, 1, 4'h1, 4'h5, 4'h9, 1, 1);
    vt[8]  = mk(0, 0, 1, 4'h2, 0, 0,  0, 1, 4'h1, 4'h2, 4'h9, 1, 1);
    vt[9]  = mk(0, 0, 1, 4'h4, 0, 0,  1, 0, 4'h1, 4'h2, 4'h4, 0, 1);
    vt[10] = mk(0, 0, 0, 4'h0, 0, 1,  1, 0, 4'h1, 4'h2, 4'h4, 0, 1);
    vt[11] = mk(0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h1, 4'h2, 4'h4, 0, 1);
    vt[12] = mk(0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h1, 4'h2, 4'h4, 0, 1);
    vt[13] = mk(0, 0, 0, 4'h0, 0, 1,  0, 1, 4'h1, 4'h2, 4'h4, 0, 2);
    // flush after b (word offered with flush is dropped), then 1,2,3 sel=0
    vt[14] = mk(0, 0, 1, 4'hA, 0, 0,  0, 1, 4'hA, 4'h2, 4'h4, 0, 2);
    vt[15] = mk(0, 0, 1, 4'hB, 0, 0,  0, 1, 4'hA, 4'hB, 4'h4, 0, 2);
    vt[16] = mk(0, 1, 1, 4'hC, 1, 0,  0, 1, 4'hA, 4'hB, 4'h4, 0, 2);
    vt[17] = mk(0, 0, 1, 4'h1, 0, 0,  0, 1, 4'h1, 4'hB, 4'h4, 0, 2);
    vt[18] = mk(0, 0, 1, 4'h2, 1, 0,  0, 1, 4'h1, 4'h2, 4'h4, 0, 2);
    vt[19] = mk(0, 0, 1, 4'h3, 0, 0,  1, 0, 4'h1, 4'h2, 4'h3, 0, 2);
    // in_valid held high during PRESENT: nothing loads
    vt[20] = mk(0, 0, 1, 4'hF, 1, 1,  1, 0, 4'h1, 4'h2, 4'h3, 0, 2);
    vt[21] = mk(0, 0, 1, 4'hF, 1, 1,  1, 0, 4'h1, 4'h2, 4'h3, 0, 2);
    vt[22] = mk(0, 0, 1, 4'hF, 1, 1,  0, 1, 4'h1, 4'h2, 4'h3, 0, 3);
    vt[23] = mk(0, 0, 0, 4'h0, 0, 0,  0, 1, 4'h1, 4'h2, 4'h3, 0, 3);
    // rst with ack during PRESENT
    vt[24] = mk(0, 0, 1, 4'h7, 0, 0,  0, 1, 4'h7, 4'h2, 4'h3, 0, 3);
    vt[25] = mk(0, 0, 1, 4'h8, 0, 0,  0, 1, 4'h7, 4'h8, 4'h3, 0, 3);
    vt[26] = mk(0, 0, 1, 4'h6, 1, 0,  1, 0, 4'h7, 4'h8, 4'h6, 1, 3);
    vt[27] = mk(1, 0, 0, 4'h0, 0, 1,  0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    vt[28] = mk(0, 0, 0, 4'h0, 0, 0,  0, 1, 4'h0, 4'h0, 4'h0, 0, 0);
  end

  // ---------------- main test ----------------
  initial begin
    @(negedge clk);

    // directed table
    for (int i = 0; i < 29; i++) begin
      rst = vt[i].rst; flush = vt[i].flush; in_valid = vt[i].in_valid;
      in_data = vt[i].in_data; in_sel = vt[i].in_sel; out_ack = vt[i].out_ack;
      step();
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vt[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vt[i].e_ir));
      chk($sformatf("v%0d_a", i), int'(a), int'(vt[i].e_a));
      chk($sformatf("v%0d_b", i), int'(b), int'(vt[i].e_b));
      chk($sformatf("v%0d_c", i), int'(c), int'(vt[i].e_c));
      chk($sformatf("v%0d_sel", i), int'(sel), int'(vt[i].e_sel));
      chk($sformatf("v%0d_frame_count", i), int'(frame_count), vt[i].e_cnt);
    end

    // flush together with an acceptable ack: frame not counted
    rst = 0; flush = 0; out_ack = 0; in_valid = 1;
    in_data = 4'h2; step();
    in_data = 4'h4; step();
    in_data = 4'h6; in_sel = 1; step();
    in_valid = 0;
    step(); step();
    chk("flush_ack_pre_valid", int'(out_valid), 1);
    flush = 1; out_ack = 1; step();
    flush = 0; out_ack = 0;
    chk("flush_ack_valid", int'(out_valid), 0);
    chk("flush_ack_count", int'(frame_count), 0);
    chk("flush_ack_ready", int'(in_ready), 1);

    // randomized run, long enough for frame_count to wrap
    for (int i = 0; i < 4000; i++) begin
      rst      = (i == 3600);
      flush    = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      in_sel   = 1'($urandom_range(0, 1));
      out_ack  = ($urandom_range(0, 9) < 6);
      step();
    end
    rst = 0; flush = 0; in_valid = 0; out_ack = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
